// File: rtl/vga_pkg.sv
// Shared constants for the 640x480@60 Hz VGA raster timing generator.
package vga_pkg;

   localparam int COORD_W = 10;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;

   // Full period of one axis, visible region plus all blanking.
   function automatic int axisTotal(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   localparam int H_TOTAL = axisTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = axisTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle handed from the timing generator to the colour stage.
interface vga_timing_if;
   import vga_pkg::*;

   logic               pix_en;
   logic               hsync;
   logic               vsync;
   logic               active;
   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;
   logic               line_start;
   logic               frame_start;

   modport master (output pix_en, hsync, vsync, active, x, y, line_start, frame_start);
   modport slave  (input  pix_en, hsync, vsync, active, x, y, line_start, frame_start);

endinterface

// File: rtl/vga_axis.sv
// One raster axis: wrapping position counter plus combinational sync/active decode.
module vga_axis
   import vga_pkg::*;
#(
   parameter int   ACTIVE = 640,
   parameter int   FP     = 16,
   parameter int   SYNC   = 96,
   parameter int   BP     = 48,
   parameter logic POL    = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_i,
   output logic               wrap_o,
   output logic [COORD_W-1:0] count_o,
   output logic               sync_o,
   output logic               active_o
);

   localparam int TOTAL = axisTotal(ACTIVE, FP, SYNC, BP);

   // Decode thresholds are one bit wider so an axis of exactly 2**COORD_W still compares cleanly.
   localparam logic [COORD_W:0] LAST       = (COORD_W+1)'(TOTAL - 1);
   localparam logic [COORD_W:0] SYNC_FIRST = (COORD_W+1)'(ACTIVE + FP);
   localparam logic [COORD_W:0] SYNC_LAST  = (COORD_W+1)'(ACTIVE + FP + SYNC - 1);
   localparam logic [COORD_W:0] ACT_END    = (COORD_W+1)'(ACTIVE);

   logic [COORD_W-1:0] count_q;
   logic [COORD_W-1:0] count_d;
   logic [COORD_W:0]   countWide;

   assign countWide = {1'b0, count_q};
   assign count_o   = count_q;
   assign sync_o    = ((countWide >= SYNC_FIRST) && (countWide <= SYNC_LAST)) ? POL : ~POL;
   assign active_o  = (countWide < ACT_END);

   // Advance on enable, returning to zero after the last position of the axis.
   always_comb begin
      wrap_o  = en_i && (countWide == LAST);
      count_d = count_q;
      if (en_i) begin
         count_d = wrap_o ? '0 : count_q + 1'b1;
      end
   end

   // Position register, cleared immediately by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: clock divider feeding horizontal and vertical axes, registered outputs.
module vga_timing #(
   parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int   H_FP     = vga_pkg::H_FP,
   parameter int   H_SYNC   = vga_pkg::H_SYNC,
   parameter int   H_BP     = vga_pkg::H_BP,
   parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int   V_FP     = vga_pkg::V_FP,
   parameter int   V_SYNC   = vga_pkg::V_SYNC,
   parameter int   V_BP     = vga_pkg::V_BP,
   parameter int   CLK_DIV  = 2,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input  logic         clk,
   input  logic         btn,
   vga_timing_if.master vga
);
   import vga_pkg::*;

   localparam int H_LEN = axisTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_LEN = axisTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);

   // Counters are COORD_W bits wide; refuse to build a raster that cannot fit.
   if ((H_LEN > (1 << COORD_W)) || (V_LEN > (1 << COORD_W)) || (CLK_DIV < 2)) begin : gBadGeometry
      $error("vga_timing: axis totals must be <= 2**COORD_W and CLK_DIV must be >= 2");
   end

   localparam int             DIV_W    = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0]   div_q;
   logic [DIV_W-1:0]   div_d;
   logic               pe;
   logic               hWrap;
   logic               vWrap;
   logic [COORD_W-1:0] hc;
   logic [COORD_W-1:0] vc;
   logic               hSync;
   logic               vSync;
   logic               hActive;
   logic               vActive;

   logic               pixEn_q;
   logic               hsync_q;
   logic               vsync_q;
   logic               active_q;
   logic [COORD_W-1:0] x_q;
   logic [COORD_W-1:0] y_q;
   logic               lineStart_q;
   logic               frameStart_q;

   assign pe = (div_q == DIV_LAST);

   // Pixel divider: free-running modulo-CLK_DIV count, strobing on its last state.
   always_comb begin
      div_d = pe ? '0 : div_q + 1'b1;
   end

   // Divider register, cleared immediately by reset.
   always_ff @(posedge clk or posedge btn) begin
      if (btn) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   vga_axis #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (HS_POL)
   ) hAxis (
      .clk      (clk),
      .rst      (btn),
      .en_i     (pe),
      .wrap_o   (hWrap),
      .count_o  (hc),
      .sync_o   (hSync),
      .active_o (hActive)
   );

   vga_axis #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (VS_POL)
   ) vAxis (
      .clk      (clk),
      .rst      (btn),
      .en_i     (pe && hWrap),
      .wrap_o   (vWrap),
      .count_o  (vc),
      .sync_o   (vSync),
      .active_o (vActive)
   );

   // Register every output from the same counter state so sync, active and coordinates stay aligned.
   always_ff @(posedge clk or posedge btn) begin
      if (btn) begin
         pixEn_q      <= 1'b0;
         hsync_q      <= ~HS_POL;
         vsync_q      <= ~VS_POL;
         active_q     <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         lineStart_q  <= 1'b0;
         frameStart_q <= 1'b0;
      end else begin
         pixEn_q      <= pe;
         hsync_q      <= hSync;
         vsync_q      <= vSync;
         active_q     <= hActive && vActive;
         x_q          <= hc;
         y_q          <= vc;
         lineStart_q  <= pe && (hc == '0);
         frameStart_q <= pe && (hc == '0) && (vc == '0);
      end
   end

   assign vga.pix_en      = pixEn_q;
   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.active      = active_q;
   assign vga.x           = x_q;
   assign vga.y           = y_q;
   assign vga.line_start  = lineStart_q;
   assign vga.frame_start = frameStart_q;

   // The vertical wrap is implied by frame_start and is not needed as a separate output.
   logic unusedWrap;
   assign unusedWrap = vWrap;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default 640x480 instance and a shrunken, inverted-polarity, divide-by-3 instance.
module tb_vga_timing;
   import vga_pkg::*;

   typedef struct packed {
      int   d;
      int   ha;
      int   hfp;
      int   hs;
      int   hbp;
      int   va;
      int   vfp;
      int   vs;
      int   vbp;
      logic hpol;
      logic vpol;
   } cfg_t;

   typedef struct packed {
      logic       pixEn;
      logic       hsync;
      logic       vsync;
      logic       active;
      logic       lineStart;
      logic       frameStart;
      logic [9:0] x;
      logic [9:0] y;
   } obs_t;

   localparam cfg_t CFG_A = '{d:2, ha:640, hfp:16, hs:96, hbp:48, va:480, vfp:10, vs:2, vbp:33, hpol:1'b0, vpol:1'b0};
   localparam cfg_t CFG_B = '{d:3, ha:20, hfp:4, hs:6, hbp:5, va:12, vfp:3, vs:2, vbp:4, hpol:1'b1, vpol:1'b1};

   logic clk = 1'b0;
   logic btn = 1'b1;
   int   nA = 0;
   int   nB = 0;
   int   assertions = 0;
   int   failures = 0;

   vga_timing_if vgaA ();
   vga_timing_if vgaB ();

   vga_timing dutA (
      .clk (clk),
      .btn (btn),
      .vga (vgaA)
   );

   vga_timing #(
      .H_ACTIVE (20),
      .H_FP     (4),
      .H_SYNC   (6),
      .H_BP     (5),
      .V_ACTIVE (12),
      .V_FP     (3),
      .V_SYNC   (2),
      .V_BP     (4),
      .CLK_DIV  (3),
      .HS_POL   (1'b1),
      .VS_POL   (1'b1)
   ) dutB (
      .clk (clk),
      .btn (btn),
      .vga (vgaB)
   );

   always #10 clk = ~clk;

   // Clock edges elapsed since reset was last released; zero while reset is held.
   always @(posedge clk or posedge btn) begin
      if (btn) begin
         nA <= 0;
         nB <= 0;
      end else begin
         nA <= nA + 1;
         nB <= nB + 1;
      end
   end

   // Expected outputs after n clock edges, from the raster rules in closed form.
   function automatic obs_t modelOut(input int n, input cfg_t c);
      obs_t o;
      int   s, p, hc, vc, ht, vt;
      ht = c.ha + c.hfp + c.hs + c.hbp;
      vt = c.va + c.vfp + c.vs + c.vbp;
      o.pixEn = 1'b0;
      o.hsync = ~c.hpol;
      o.vsync = ~c.vpol;
      o.active = 1'b0;
      o.lineStart = 1'b0;
      o.frameStart = 1'b0;
      o.x = '0;
      o.y = '0;
      if (n > 0) begin
         s = n - 1;
         p = s / c.d;
         hc = p % ht;
         vc = (p / ht) % vt;
         o.pixEn = ((s % c.d) == c.d - 1);
         o.x = 10'(hc);
         o.y = 10'(vc);
         o.hsync = (hc >= c.ha + c.hfp && hc < c.ha + c.hfp + c.hs) ? c.hpol : ~c.hpol;
         o.vsync = (vc >= c.va + c.vfp && vc < c.va + c.vfp + c.vs) ? c.vpol : ~c.vpol;
         o.active = (hc < c.ha) && (vc < c.va);
         o.lineStart = o.pixEn && (hc == 0);
         o.frameStart = o.pixEn && (hc == 0) && (vc == 0);
      end
      return o;
   endfunction

   function automatic obs_t obsA();
      return '{pixEn:vgaA.pix_en, hsync:vgaA.hsync, vsync:vgaA.vsync, active:vgaA.active,
               lineStart:vgaA.line_start, frameStart:vgaA.frame_start, x:vgaA.x, y:vgaA.y};
   endfunction

   function automatic obs_t obsB();
      return '{pixEn:vgaB.pix_en, hsync:vgaB.hsync, vsync:vgaB.vsync, active:vgaB.active,
               lineStart:vgaB.line_start, frameStart:vgaB.frame_start, x:vgaB.x, y:vgaB.y};
   endfunction

   // Compare one observed value against its required value and tally the outcome.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      assertions++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Drive the reset button.
   task automatic applyStimulus(input logic value);
      btn = value;
   endtask

   // Every cycle, both instances must match the model.
   always @(negedge clk) begin
      checkOutput("modelA", {6'b0, obsA()}, {6'b0, modelOut(nA, CFG_A)});
      checkOutput("modelB", {6'b0, obsB()}, {6'b0, modelOut(nB, CFG_B)});
   end

   int hLow, aLow, lsCount, hMinX, hMaxX;
   int vHigh, maxX, maxY, vMinY, vMaxY, fsFirst, fsSecond, wrapChecks;
   bit wrapPending, found;

   initial begin
      applyStimulus(1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rstPixEnA", 32'(vgaA.pix_en), 32'd0);
      checkOutput("rstHsyncA", 32'(vgaA.hsync), 32'd1);
      checkOutput("rstVsyncA", 32'(vgaA.vsync), 32'd1);
      checkOutput("rstHsyncB", 32'(vgaB.hsync), 32'd0);
      checkOutput("rstVsyncB", 32'(vgaB.vsync), 32'd0);
      #3 applyStimulus(1'b0);

      @(negedge clk);
      checkOutput("relPixEn0A", 32'(vgaA.pix_en), 32'd0);
      @(negedge clk);
      checkOutput("relPixEn1A", 32'(vgaA.pix_en), 32'd1);
      checkOutput("relFrameA", 32'({vgaA.frame_start, vgaA.line_start, vgaA.active}), 32'h7);
      checkOutput("relXYA", 32'({vgaA.x, vgaA.y}), 32'd0);
      checkOutput("relSyncA", 32'({vgaA.hsync, vgaA.vsync}), 32'h3);

      // One full line of the default instance, starting at its first pixel strobe.
      hLow = 0; aLow = 0; lsCount = 0; hMinX = 1023; hMaxX = 0;
      for (int i = 0; i < 1600; i++) begin
         if (!vgaA.hsync) hLow++;
         if (!vgaA.active) aLow++;
         if (vgaA.line_start) lsCount++;
         if (vgaA.pix_en && !vgaA.hsync) begin
            if (int'(vgaA.x) < hMinX) hMinX = int'(vgaA.x);
            if (int'(vgaA.x) > hMaxX) hMaxX = int'(vgaA.x);
         end
         if (nA == 1280) checkOutput("activeLastA", 32'(vgaA.active), 32'd1);
         if (nA == 1281) checkOutput("activeOffA", 32'(vgaA.active), 32'd0);
         if (nA == 1312) checkOutput("hsyncPreA", 32'(vgaA.hsync), 32'd1);
         if (nA == 1313) checkOutput("hsyncFallA", 32'(vgaA.hsync), 32'd0);
         if (nA == 1504) checkOutput("hsyncLastA", 32'(vgaA.hsync), 32'd0);
         if (nA == 1505) checkOutput("hsyncRiseA", 32'(vgaA.hsync), 32'd1);
         if (nB == 2) checkOutput("relPixEn0B", 32'(vgaB.pix_en), 32'd0);
         if (nB == 3) checkOutput("relFrameB", 32'({vgaB.pix_en, vgaB.frame_start, vgaB.x, vgaB.y}), 32'h3 << 20);
         @(negedge clk);
      end
      checkOutput("hsyncLowClks", 32'(hLow), 32'd192);
      checkOutput("activeLowClks", 32'(aLow), 32'd320);
      checkOutput("lineStartsInLine", 32'(lsCount), 32'd1);
      checkOutput("hsyncMinX", 32'(hMinX), 32'd656);
      checkOutput("hsyncMaxX", 32'(hMaxX), 32'd751);
      checkOutput("lineStartPeriod", 32'({vgaA.line_start, vgaA.x, vgaA.y}), 32'((1 << 20) | 1));

      // Two full frames of the small instance: vsync width, coordinate limits and the frame wrap.
      vHigh = 0; maxX = 0; maxY = 0; vMinY = 1023; vMaxY = 0;
      fsFirst = -1; fsSecond = -1; wrapChecks = 0; wrapPending = 1'b0;
      while (nB < 4420) begin
         if (vgaB.frame_start) begin
            if (fsFirst < 0) fsFirst = nB;
            else if (fsSecond < 0) fsSecond = nB;
         end
         if (nB >= 2208 && nB < 4413 && vgaB.vsync) vHigh++;
         if (vgaB.pix_en) begin
            if (int'(vgaB.x) > maxX) maxX = int'(vgaB.x);
            if (int'(vgaB.y) > maxY) maxY = int'(vgaB.y);
            if (vgaB.vsync) begin
               if (int'(vgaB.y) < vMinY) vMinY = int'(vgaB.y);
               if (int'(vgaB.y) > vMaxY) vMaxY = int'(vgaB.y);
            end
            if (wrapPending) begin
               checkOutput("wrapNextB", 32'({vgaB.frame_start, vgaB.x, vgaB.y}), 32'(1 << 20));
               wrapChecks++;
               wrapPending = 1'b0;
            end
            if (vgaB.x == 10'd34 && vgaB.y == 10'd20) wrapPending = 1'b1;
         end
         @(negedge clk);
      end
      checkOutput("frameStartFirstB", 32'(fsFirst), 32'd2208);
      checkOutput("framePeriodB", 32'(fsSecond - fsFirst), 32'd2205);
      checkOutput("vsyncHighClksB", 32'(vHigh), 32'd210);
      checkOutput("maxXB", 32'(maxX), 32'd34);
      checkOutput("maxYB", 32'(maxY), 32'd20);
      checkOutput("vsyncMinYB", 32'(vMinY), 32'd15);
      checkOutput("vsyncMaxYB", 32'(vMaxY), 32'd16);
      checkOutput("wrapChecksB", 32'(wrapChecks), 32'd2);

      // Reset in the middle of a frame, between clock edges.
      found = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
         if (vgaB.pix_en && vgaB.x == 10'd17 && vgaB.y == 10'd10) found = 1'b1;
         else @(negedge clk);
      end
      checkOutput("midFrameReached", 32'(found), 32'd1);
      #7 applyStimulus(1'b1);
      #1;
      checkOutput("midRstA", {6'b0, obsA()}, {6'b0, 2'b01, 2'b10, 2'b00, 20'd0});
      checkOutput("midRstB", {6'b0, obsB()}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #3 applyStimulus(1'b0);
      @(negedge clk);
      checkOutput("rerelPixEn0A", 32'(vgaA.pix_en), 32'd0);
      @(negedge clk);
      checkOutput("rerelFrameA", 32'({vgaA.pix_en, vgaA.frame_start, vgaA.line_start, vgaA.active, vgaA.x, vgaA.y}), 32'hF << 20);
      @(negedge clk);
      checkOutput("rerelFrameB", 32'({vgaB.pix_en, vgaB.frame_start, vgaB.x, vgaB.y}), 32'h3 << 20);
      repeat (200) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
